// File: rtl/spi_mem_writer.sv
// spi_mem_writer
//   SPI-slave-side memory writer. Serial bits arrive on si (MSB first) whenever
//   sel and the one-clock SCK-rising strobe are both high. Every completed
//   16-bit word is presented to a dual-port memory as wdata/addr with a
//   one-clock we pulse. The address auto-increments after each write.
//
// Parameters
//   AW    memory address width (depth = 2**AW words)
//   WRAP  1: address wraps to 0 after the last word
//         0: writing stops at the last word and full is raised
//
// Ports
//   clk         system clock, posedge
//   reset_n     asynchronous active-low reset
//   sel         chip-select active
//   rising      one-clock strobe, SCK rising edge (sample si)
//   si          serial data in
//   reset_flag  synchronous frame restart, same effect as reset
//   wdata       memory write data
//   addr        memory write address
//   we          memory write enable, one clock per completed word
//   full        memory filled (WRAP=0 only), further words discarded
//   words       words written since reset/reset_flag, saturates at 2**AW
//   dbg_state   current FSM state (IDLE=0, SHIFT=1, COMMIT=2, FULL=3)
//
// Handshake: there is no back-pressure. A word is transferred on every clock
// in which we is high; wdata and addr are stable for that whole clock.

module spi_mem_writer #(
    parameter int AW   = 12,
    parameter bit WRAP = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sel,
    input  logic          rising,
    input  logic          si,
    input  logic          reset_flag,
    output logic [15:0]   wdata,
    output logic [AW-1:0] addr,
    output logic          we,
    output logic          full,
    output logic [AW:0]   words,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2,
        S_FULL   = 2'd3
    } state_e;

    localparam logic [AW-1:0] ADDR_LAST = '1;
    localparam logic [AW:0]   WORDS_MAX = {1'b1, {AW{1'b0}}};

    state_e        state_q, state_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [3:0]    bit_ctr_q, bit_ctr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   words_q, words_d;

    logic sample;
    logic last_bit;

    // Once full, the shift path is frozen so no further words can complete.
    assign sample   = sel & rising & (state_q != S_FULL);
    assign last_bit = sample & (bit_ctr_q == 4'd0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (last_bit) begin
                    state_d = S_COMMIT;
                end else if (sample) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (!WRAP && (addr_q == ADDR_LAST)) begin
                    state_d = S_FULL;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_FULL: begin
                state_d = S_FULL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A frame restart wins over everything, including a completing word.
        if (reset_flag) begin
            state_d = S_IDLE;
        end
    end

    // COMMIT lasts exactly one clock, so decoding it gives the we pulse.
    always_comb begin
        we        = (state_q == S_COMMIT);
        full      = (state_q == S_FULL);
        dbg_state = state_q;
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        shreg_d   = shreg_q;
        bit_ctr_d = bit_ctr_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        words_d   = words_q;

        // The shift path runs independently of COMMIT, so a bit arriving
        // during the write cycle still lands in the next word.
        if (sample) begin
            shreg_d   = {shreg_q[14:0], si};
            bit_ctr_d = bit_ctr_q - 4'd1;
        end
        if (last_bit) begin
            wdata_d = {shreg_q[14:0], si};
        end

        // Address and count advance on the clock after the we pulse, so
        // addr is stable while we is high.
        if (state_q == S_COMMIT) begin
            if (words_q != WORDS_MAX) begin
                words_d = words_q + 1'b1;
            end
            if (addr_q != ADDR_LAST) begin
                addr_d = addr_q + 1'b1;
            end else if (WRAP) begin
                addr_d = '0;
            end
        end

        if (reset_flag) begin
            shreg_d   = '0;
            bit_ctr_d = 4'd15;
            wdata_d   = '0;
            addr_d    = '0;
            words_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            bit_ctr_q <= 4'd15;
            wdata_q   <= '0;
            addr_q    <= '0;
            words_q   <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_ctr_q <= bit_ctr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            words_q   <= words_d;
        end
    end

    assign wdata = wdata_q;
    assign addr  = addr_q;
    assign words = words_q;

endmodule
